// File: rtl/interrupt_controller.sv
// Interrupt initiator for fetch: edge capture, fixed-priority arbitration, req/ack/reti FSM.
// Define INT_NESTING_EN to allow lower-index sources to preempt a running handler.
module interrupt_controller #(
   parameter int          NUM_SRC       = 4,
   parameter logic [31:0] VECTOR_BASE   = 32'h0000_0010,
   parameter logic [31:0] VECTOR_STRIDE = 32'h0000_0004
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [NUM_SRC-1:0] i_irq,
   input  logic [NUM_SRC-1:0] i_mask,
   input  logic               i_ack,
   input  logic               i_reti,
   output logic               o_interrupt,
   output logic [31:0]        o_vector,
   output logic [2:0]         o_src_id,
   output logic               o_in_service,
   output logic [NUM_SRC-1:0] o_pending
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] SERVICE = 2'd2;

   logic [1:0]         state;
   logic [NUM_SRC-1:0] sync1, sync2, prev;
   logic [NUM_SRC-1:0] irq_edge, cand, clr;
   logic               ack_fire;
   logic               win_vld;
   logic [2:0]         win_id;
   logic [31:0]        win_vec;

`ifdef INT_NESTING_EN
   logic [2:0] stack [NUM_SRC];
   logic [3:0] depth;
`endif

   assign irq_edge = sync2 & ~prev;
   assign ack_fire = (state == REQ) && i_ack;
   assign win_vec  = VECTOR_BASE + VECTOR_STRIDE * {29'd0, win_id};

   always_comb begin
      cand = o_pending & ~i_mask;
`ifdef INT_NESTING_EN
      // only strictly higher priority than the running handler may preempt
      if (state == SERVICE) begin
         for (int n = 0; n < NUM_SRC; n++) begin
            if (3'(n) >= stack[0]) cand[n] = 1'b0;
         end
      end
`endif
   end

   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int n = NUM_SRC - 1; n >= 0; n--) begin
         if (cand[n]) begin
            win_vld = 1'b1;
            win_id  = 3'(n);
         end
      end
   end

   always_comb begin
      clr = '0;
      for (int n = 0; n < NUM_SRC; n++) begin
         clr[n] = ack_fire && (o_src_id == 3'(n));
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         sync1        <= '0;
         sync2        <= '0;
         prev         <= '0;
         o_pending    <= '0;
         state        <= IDLE;
         o_interrupt  <= 1'b0;
         o_vector     <= '0;
         o_src_id     <= '0;
         o_in_service <= 1'b0;
`ifdef INT_NESTING_EN
         depth        <= '0;
         for (int i = 0; i < NUM_SRC; i++) stack[i] <= '0;
`endif
      end else begin
         sync1     <= i_irq;
         sync2     <= sync1;
         prev      <= sync2;
         // a fresh edge beats the ack clear on the same source
         o_pending <= (o_pending & ~clr) | irq_edge;
         unique case (state)
            IDLE: begin
               if (win_vld) begin
                  state       <= REQ;
                  o_src_id    <= win_id;
                  o_vector    <= win_vec;
                  o_interrupt <= 1'b1;
               end
            end
            REQ: begin
               if (i_ack) begin
                  state        <= SERVICE;
                  o_interrupt  <= 1'b0;
                  o_in_service <= 1'b1;
`ifdef INT_NESTING_EN
                  depth    <= depth + 4'd1;
                  stack[0] <= o_src_id;
                  for (int i = NUM_SRC - 1; i > 0; i--) stack[i] <= stack[i-1];
`endif
               end
            end
            SERVICE: begin
`ifdef INT_NESTING_EN
               if (i_reti) begin
                  depth <= depth - 4'd1;
                  for (int i = 0; i < NUM_SRC - 1; i++) stack[i] <= stack[i+1];
                  stack[NUM_SRC-1] <= '0;
                  if (depth == 4'd1) begin
                     state        <= IDLE;
                     o_in_service <= 1'b0;
                  end else begin
                     o_src_id <= stack[1];
                  end
               end else if (win_vld) begin
                  state       <= REQ;
                  o_src_id    <= win_id;
                  o_vector    <= win_vec;
                  o_interrupt <= 1'b1;
               end
`else
               if (i_reti) begin
                  state        <= IDLE;
                  o_in_service <= 1'b0;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Initiator end of the CPU interrupt interface: collects external interrupt lines, arbitrates them and drives the interrupt request into the fetch stage.
- Holds the request until the core acknowledges it, then supplies the vector PC.
- Tracks the in-service source until the core signals return-from-interrupt.
- Sits beside fetch_stage; replaces the constant-0 interrupt input of fetch and decode.

Parameters:
- NUM_SRC, 4: number of interrupt sources (2..8).
- VECTOR_BASE, 32'h0000_0010: PC of the source-0 handler.
- VECTOR_STRIDE, 32'h0000_0004: PC spacing between consecutive source handlers.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_irq  input  NUM_SRC  asynchronous interrupt lines, rising-edge triggered.
- i_mask  input  NUM_SRC  1 = source blocked from arbitration; does not block pending capture.
- i_ack  input  1  one-cycle pulse from fetch when it accepts the interrupt (PC pushed).
- i_reti  input  1  one-cycle pulse from EXM when the return-from-interrupt pop_pc completes.
- o_interrupt  output  1  registered interrupt request to fetch/decode.
- o_vector  output  32  handler PC; valid and stable while o_interrupt=1.
- o_src_id  output  3  selected / in-service source index.
- o_in_service  output  1  a handler is executing.
- o_pending  output  NUM_SRC  pending register.

Behaviour:
- Reset (i_reset=0, asynchronous): all of the following clear to 0: synchronizers, pending, state=IDLE, o_interrupt, o_vector, o_src_id, o_in_service.
- Input capture:
  - Per line: 2-flop synchronizer, then a previous-value flop; edge = sync & ~prev.
  - Edge sets pending[n] on the next clock.
  - i_irq first sampled high at edge k gives pending[n]=1 after edge k+2.
  - Level held high gives exactly one pending set.
- Arbitration: eligible = pending & ~i_mask. Lowest index wins (fixed priority).
- FSM, states IDLE / REQ / SERVICE:
  - IDLE: if eligible != 0, go to REQ at the next edge. Latch the winner into o_src_id, set o_vector = VECTOR_BASE + id*VECTOR_STRIDE (32-bit, wraps modulo 2^32), set o_interrupt=1. First request after an edge at k: o_interrupt=1 after edge k+3.
  - REQ: o_interrupt, o_vector and o_src_id are held stable. No re-arbitration, even if a higher-priority source pends or the selected source becomes masked.
  - REQ with i_ack=1: clear pending[o_src_id], set o_interrupt=0 and o_in_service=1, go to SERVICE.
  - SERVICE with i_reti=1: o_in_service=0, go to IDLE. A new request may assert on the edge after IDLE is entered.
- Boundary cases:
  - i_ack outside REQ: ignored.
  - i_reti outside SERVICE: ignored.
  - Capture edge and ack clear on the same source in the same cycle: set wins, pending stays 1.
  - Edges arriving while a source is already pending: merged into the single pending bit (no count).
  - Reset asserted mid-REQ or mid-SERVICE: immediate return to IDLE; all pending lost.
  - All eligible sources masked: remain in IDLE; pending bits retained.

Optional Feature:
- Macro: INT_NESTING_EN.
- Defined:
  - In SERVICE, an eligible source with index strictly lower than the current top of stack enters REQ (preemption). o_in_service stays 1.
  - On i_ack the new id is pushed onto an in-service stack of depth NUM_SRC; o_src_id shows the top of stack.
  - i_reti pops the stack. Return to IDLE only when the stack becomes empty; otherwise remain in SERVICE.
  - Equal- or lower-priority sources wait until the stack is empty or a lower-priority level is on top.
- Undefined: no stack; no request is raised while in SERVICE.

Test Plan:
- Reset, then i_irq[2] rising at edge 5 -> pending[2]=1 after edge 7; o_interrupt=1 with o_vector=32'h18 and o_src_id=2 after edge 8; held until i_ack.
- i_irq[3] and i_irq[1] rise in the same cycle -> src 1 (vector 32'h14) served first; after i_ack then i_reti, src 3 (vector 32'h1C) is requested.
- i_mask=4'b0001, i_irq[0] pulses -> pending[0]=1 with no request; clearing the mask -> o_interrupt=1, src 0, vector 32'h10.
- In REQ for src 2, i_irq[0] rises -> o_src_id stays 2 until i_ack. Same-cycle i_irq[2] edge with i_ack -> pending[2] remains 1.
- Reset pulsed low during SERVICE -> o_in_service, o_interrupt and o_pending are 0 immediately, asynchronously to the clock.
- (INT_NESTING_EN) serving src 3, i_irq[1] rises -> o_interrupt=1, vector 32'h14. After i_ack: o_src_id=1. First i_reti -> o_src_id=3, still in service. Second i_reti -> IDLE.
